gray_updown_counter: RTL and testbench
======================================

// Module: gray_updown_counter
// PURPOSE
//   Parametrised WIDTH-bit Gray-code counter: up/down counting, synchronous load,
//   wrap or saturate mode, sticky overflow/underflow flags and a one-cycle boundary
//   pulse. Generational successor to the fixed 3-bit Gray counter. Used as a
//   sequencer and as a pointer source for clock-crossing pointer logic.
// PARAMETERS
//   WIDTH     3   counter width in bits, legal range 2..16
//   SATURATE  0   0: wrap at the ends (max<->0); 1: hold at the ends
// PORTS
//   Clk       in   1      rising-edge clock
//   Reset_n   in   1      asynchronous, active-low reset
//   En        in   1      count enable; advances one step per Clk edge while high
//   Up        in   1      direction: 1 = increment, 0 = decrement
//   Load      in   1      synchronous load of LoadVal
//   LoadVal   in   WIDTH  Gray-coded value to load
//   ClrFlag   in   1      synchronous clear of Overflow and Underflow
//   Output    out  WIDTH  current count, Gray code, registered
//   Binary    out  WIDTH  current count, binary, registered
//   Overflow  out  1      sticky: an up step was attempted at count max
//   Underflow out  1      sticky: a down step was attempted at count 0
//   Boundary  out  1      one-cycle pulse: the previous edge hit an end
// BEHAVIOUR
//   - State: binary register bin[WIDTH-1:0] plus flag registers.
//     Output = bin ^ (bin >> 1). Both outputs come from registers, so Output and
//     Binary change only on a Clk edge.
//   - Reset (Reset_n=0): takes effect immediately, independent of Clk.
//     bin=0, Output=0, Binary=0, Overflow=0, Underflow=0, Boundary=0.
//     Reset is released synchronously to Clk outside this block.
//   - Priority each edge: Load > En. ClrFlag is evaluated independently.
//   - Load=1: bin <= gray2bin(LoadVal), where b[i] = ^LoadVal[WIDTH-1:i].
//     Load ignores En and Up, leaves the flags unchanged, and forces Boundary=0.
//   - Load=0, En=1, Up=1:
//       bin<max: bin+1.
//       bin==max: SATURATE=0 gives bin<=0; SATURATE=1 holds bin.
//       In both modes at max: Overflow<=1 and Boundary<=1.
//   - Load=0, En=1, Up=0:
//       bin>0: bin-1.
//       bin==0: SATURATE=0 gives bin<=max; SATURATE=1 holds bin.
//       In both modes at 0: Underflow<=1 and Boundary<=1.
//   - Load=0, En=0: bin holds and Boundary<=0.
//   - Boundary is high for exactly one cycle after each edge that hit an end.
//     Consecutive boundary edges (saturate mode with En held high) keep it high.
//   - Arithmetic is modulo 2^WIDTH; max = 2^WIDTH-1. Successive Output values
//     always differ in exactly one bit, including across a wrap (0 <-> max).
//   - ClrFlag=1 clears Overflow and Underflow on the edge. If the same edge sets
//     a flag, the set wins for that flag; the other flag is cleared.
//   - Latency: one edge from input to the registered outputs.
//     There is no combinational path from inputs to outputs.
// TESTING
//   1. WIDTH=3, SATURATE=0, Reset_n pulse, then En=1 Up=1 for 8 edges
//      -> Output 001,011,010,110,111,101,100,000.
//      -> Overflow=1 from the 8th edge; Boundary=1 for one cycle after the 8th edge.
//   2. From 0 (fresh reset), En=1 Up=0 for 1 edge
//      -> Output=100, Binary=7, Underflow=1, Overflow=0, Boundary pulse.
//   3. SATURATE=1, Load LoadVal=100 (bin 7), then En=1 Up=1 for 3 edges
//      -> Output stays 100, Overflow=1, Boundary high for all 3 cycles.
//   4. Load=1 LoadVal=110 with En=1 on the same edge
//      -> Binary=4, Output=110, no count step, flags unchanged.
//   5. Overflow=1, then ClrFlag=1 with Up=1 at max on the same edge
//      -> Overflow stays 1. ClrFlag at a non-boundary edge -> Overflow=0.
//   6. Drop Reset_n mid-count, between clock edges (count 5)
//      -> all outputs are 0 before the next Clk edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter.
// master: the side that drives En/Up/Load/LoadVal/ClrFlag and observes the count.
// slave:  the counter itself; drives Output/Binary/Overflow/Underflow/Boundary.
interface gray_updown_counter_if #(
   parameter int WIDTH = 3
);
   logic             En;
   logic             Up;
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic             ClrFlag;
   logic [WIDTH-1:0] Output;
   logic [WIDTH-1:0] Binary;
   logic             Overflow;
   logic             Underflow;
   logic             Boundary;

   modport master (
      output En, Up, Load, LoadVal, ClrFlag,
      input  Output, Binary, Overflow, Underflow, Boundary
   );

   modport slave (
      input  En, Up, Load, LoadVal, ClrFlag,
      output Output, Binary, Overflow, Underflow, Boundary
   );
endinterface

// File: rtl/gray_updown_counter.sv
// Purpose: WIDTH-bit up/down Gray counter with load, wrap/saturate, sticky flags, boundary pulse.
// Latency: one Clk edge from inputs to every output; all outputs are registered.
// Backpressure: none; En advances one step per edge, Load takes priority over En.
//
// Ports:
//   Clk, Reset_n        rising-edge clock, asynchronous active-low reset
//   bus.En/Up           count enable and direction (1 = up)
//   bus.Load/LoadVal    synchronous load of a Gray-coded value
//   bus.ClrFlag         synchronous clear of the sticky flags
//   bus.Output/Binary   current count in Gray and binary
//   bus.Overflow/Underflow  sticky end-of-range attempts
//   bus.Boundary        one-cycle pulse after an edge that hit an end
module gray_updown_counter #(
   parameter int WIDTH    = 3,
   parameter bit SATURATE = 1'b0
) (
   input logic                  Clk,
   input logic                  Reset_n,
   gray_updown_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             ovf_q;
   logic             unf_q;
   logic             bnd_q;

   logic [WIDTH-1:0] bin_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;
   logic             bnd_nxt;

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      bin_nxt = bin_q;
      bnd_nxt = 1'b0;
      // Clear first, so a flag set on the same edge below overrides the clear.
      ovf_nxt = bus.ClrFlag ? 1'b0 : ovf_q;
      unf_nxt = bus.ClrFlag ? 1'b0 : unf_q;

      if (bus.Load) begin
         bin_nxt = gray2bin(bus.LoadVal);
      end else if (bus.En) begin
         if (bus.Up) begin
            if (bin_q == MAX_VAL) begin
               bin_nxt = SATURATE ? bin_q : '0;
               ovf_nxt = 1'b1;
               bnd_nxt = 1'b1;
            end else begin
               bin_nxt = bin_q + ONE;
            end
         end else begin
            if (bin_q == '0) begin
               bin_nxt = SATURATE ? bin_q : MAX_VAL;
               unf_nxt = 1'b1;
               bnd_nxt = 1'b1;
            end else begin
               bin_nxt = bin_q - ONE;
            end
         end
      end
   end

   // Gray value is registered from the next binary value so Output never
   // carries a combinational decode glitch into a clock-crossing synchroniser.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bin_q  <= '0;
         gray_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         bnd_q  <= 1'b0;
      end else begin
         bin_q  <= bin_nxt;
         gray_q <= bin_nxt ^ (bin_nxt >> 1);
         ovf_q  <= ovf_nxt;
         unf_q  <= unf_nxt;
         bnd_q  <= bnd_nxt;
      end
   end

   assign bus.Output    = gray_q;
   assign bus.Binary    = bin_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
   assign bus.Boundary  = bnd_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a wrapping and a saturating instance driven
// with identical stimulus and compared against a behavioural integer model.
module tb_gray_updown_counter;

   localparam int W    = 3;
   localparam int MAXV = 7;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   gray_updown_counter_if #(.WIDTH(W)) bus_w ();
   gray_updown_counter_if #(.WIDTH(W)) bus_s ();

   gray_updown_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus_w.slave)
   );
   gray_updown_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus_s.slave)
   );

   int tests = 0;
   int fails = 0;

   // Reflected Gray code sequence for 3 bits, written out as a table.
   int gtab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

   // Model state, index 0 = wrap instance, 1 = saturate instance.
   int m_cnt [2];
   bit m_ovf [2];
   bit m_unf [2];
   bit m_bnd [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Position of a Gray code in the sequence is its binary value.
   function automatic int gray_to_int(input int g);
      for (int v = 0; v <= MAXV; v++) if (gtab[v] == g) return v;
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_cnt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_bnd[m] = 0;
      end
   endtask

   task automatic model_edge(input int m, input bit en, input bit up, input bit ld,
                             input int lv, input bit clr);
      bit sat;
      sat = (m == 1);
      if (clr) begin
         m_ovf[m] = 0;
         m_unf[m] = 0;
      end
      m_bnd[m] = 0;
      if (ld) begin
         m_cnt[m] = gray_to_int(lv);
      end else if (en && up) begin
         if (m_cnt[m] == MAXV) begin
            m_ovf[m] = 1; m_bnd[m] = 1;
            if (!sat) m_cnt[m] = 0;
         end else m_cnt[m] = m_cnt[m] + 1;
      end else if (en) begin
         if (m_cnt[m] == 0) begin
            m_unf[m] = 1; m_bnd[m] = 1;
            if (!sat) m_cnt[m] = MAXV;
         end else m_cnt[m] = m_cnt[m] - 1;
      end
   endtask

   task automatic check_all();
      check("wrap.gray", bus_w.Output,    gtab[m_cnt[0]]);
      check("wrap.bin",  bus_w.Binary,    m_cnt[0]);
      check("wrap.ovf",  bus_w.Overflow,  m_ovf[0]);
      check("wrap.unf",  bus_w.Underflow, m_unf[0]);
      check("wrap.bnd",  bus_w.Boundary,  m_bnd[0]);
      check("sat.gray",  bus_s.Output,    gtab[m_cnt[1]]);
      check("sat.bin",   bus_s.Binary,    m_cnt[1]);
      check("sat.ovf",   bus_s.Overflow,  m_ovf[1]);
      check("sat.unf",   bus_s.Underflow, m_unf[1]);
      check("sat.bnd",   bus_s.Boundary,  m_bnd[1]);
   endtask

   task automatic drive(input bit en, input bit up, input bit ld, input int lv, input bit clr);
      logic [W-1:0] lvv;
      lvv = lv[W-1:0];
      bus_w.En = en; bus_w.Up = up; bus_w.Load = ld; bus_w.LoadVal = lvv; bus_w.ClrFlag = clr;
      bus_s.En = en; bus_s.Up = up; bus_s.Load = ld; bus_s.LoadVal = lvv; bus_s.ClrFlag = clr;
   endtask

   task automatic step(input bit en, input bit up, input bit ld, input int lv, input bit clr);
      drive(en, up, ld, lv, clr);
      @(posedge Clk);
      #1;
      for (int m = 0; m < 2; m++) model_edge(m, en, up, ld, lv, clr);
      check_all();
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic async_reset();
      step(0, 0, 0, 0, 0);
      #3;
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1_exp [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
      bit r_up;

      Reset_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;

      // Count up through a full wrap.
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 0, 0, 0);
         check("t1.seq", bus_w.Output, t1_exp[i]);
      end
      check("t1.ovf", bus_w.Overflow, 1);
      check("t1.bnd", bus_w.Boundary, 1);
      step(0, 0, 0, 0, 0);
      check("t1.bnd_drop", bus_w.Boundary, 0);

      // Down step from zero.
      async_reset();
      step(1, 0, 0, 0, 0);
      check("t2.gray", bus_w.Output, 4);
      check("t2.bin",  bus_w.Binary, 7);
      check("t2.unf",  bus_w.Underflow, 1);
      check("t2.ovf",  bus_w.Overflow, 0);
      check("t2.bnd",  bus_w.Boundary, 1);

      // Saturate at max for three edges.
      step(0, 0, 1, 4, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 0);
         check("t3.gray", bus_s.Output, 4);
         check("t3.ovf",  bus_s.Overflow, 1);
         check("t3.bnd",  bus_s.Boundary, 1);
      end

      // Load beats En.
      step(1, 1, 1, 6, 0);
      check("t4.bin",  bus_w.Binary, 4);
      check("t4.gray", bus_w.Output, 6);
      check("t4.bnd",  bus_w.Boundary, 0);

      // Set beats clear on the same edge; plain clear afterwards.
      step(0, 0, 1, 4, 0);
      step(1, 1, 0, 0, 1);
      check("t5.ovf_set_wins", bus_w.Overflow, 1);
      check("t5.unf_cleared",  bus_w.Underflow, 0);
      step(0, 0, 0, 0, 1);
      check("t5.ovf_cleared",  bus_w.Overflow, 0);

      // Reset mid-count at 5, then resume from 0.
      async_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
      check("t6.pre_bin", bus_w.Binary, 5);
      async_reset();
      step(1, 1, 0, 0, 0);
      check("t6.resume", bus_w.Binary, 1);

      // Randomised run with direction held in runs so both ends are reached.
      r_up = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) r_up = ~r_up;
         if ($urandom_range(0, 79) == 0) begin
            async_reset();
         end else begin
            step(($urandom_range(0, 3) != 0), r_up, ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, MAXV)), ($urandom_range(0, 7) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
